// File: rtl/dwt_pair_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dwt_pair_packer_pkg
// Purpose  : Shared DWT types: packer FSM states and the {eol, sof, odd, even}
//            pair layout consumed by the lifting unit.
// Revision : 1.0 - initial release
// ============================================================================
package dwt_pair_packer_pkg;

    localparam int c_DWT_DATA_WIDTH = 16;

    typedef enum logic [0:0] {
        EVEN = 1'b0,
        ODD  = 1'b1
    } pack_state_e;

    typedef struct packed {
        logic                               eol;
        logic                               sof;
        logic signed [c_DWT_DATA_WIDTH-1:0] odd;
        logic signed [c_DWT_DATA_WIDTH-1:0] even;
    } pair_t;

    // Flat width of a pair beat for a given sample width (same layout as pair_t).
    function automatic int pair_width(input int data_width);
        return 2 * data_width + 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dwt_pair_packer_axis_reg.sv
`default_nettype none
// ============================================================================
// Module   : dwt_pair_packer_axis_reg
// Purpose  : Non-transparent AXI-Stream register slice; output is held stable
//            while valid and not ready.
// Revision : 1.0 - initial release
// ============================================================================
module dwt_pair_packer_axis_reg #(
    parameter int WIDTH = 34
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    input  logic [WIDTH-1:0] s_data_i,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [WIDTH-1:0] m_data_o
);

    assign s_ready_o = !m_valid_o || m_ready_i;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            m_valid_o <= 1'b0;
            m_data_o  <= '0;
        end else if (s_ready_o) begin
            m_valid_o <= s_valid_i;
            if (s_valid_i) begin
                m_data_o <= s_data_i;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dwt_pair_packer.sv
`default_nettype none
// ============================================================================
// Module   : dwt_pair_packer
// Purpose  : Packs a serial sample stream into {odd, even} pairs with sof/eol,
//            mirroring x[N-2] to complete odd-length lines.
//            Optional DWT_PACK_ERR_EN adds a line-length counter and err_o.
// Revision : 1.0 - initial release
// ============================================================================
module dwt_pair_packer
    import dwt_pair_packer_pkg::*;
#(
    parameter int DATA_WIDTH = c_DWT_DATA_WIDTH
`ifdef DWT_PACK_ERR_EN
    ,
    parameter int MAXIMUM_SIDE_SIZE = 512
`endif
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    output logic                         s_ready_o,
    input  logic                         s_valid_i,
    input  logic                         s_sof_i,
    input  logic                         s_eol_i,
    input  logic signed [DATA_WIDTH-1:0] s_data_i,
    input  logic                         m_ready_i,
    output logic                         m_valid_o,
    output logic                         m_sof_o,
    output logic                         m_eol_o,
    output logic [2*DATA_WIDTH-1:0]      m_data_o
`ifdef DWT_PACK_ERR_EN
    ,
    output logic                         err_o
`endif
);

    localparam int c_PAIR_W = pair_width(DATA_WIDTH);

    pack_state_e                  r_state;
    logic                         r_rdy;
    logic signed [DATA_WIDTH-1:0] r_even;
    logic signed [DATA_WIDTH-1:0] r_last_odd;
    logic                         r_sof;
    logic                         r_have_odd;

    logic                         w_out_free;
    logic                         w_in_xfer;
    logic                         w_as_even;
    logic                         w_emit;
    logic [c_PAIR_W-1:0]          w_pair;
    logic [c_PAIR_W-1:0]          w_out_pair;

    // A beat that cannot emit a pair is always accepted in EVEN; anything that
    // produces a pair must wait for the output register to be free.
    always_comb begin
        s_ready_o = 1'b0;
        if (r_rdy) begin
            if (r_state == ODD) begin
                s_ready_o = w_out_free;
            end else begin
                s_ready_o = !s_eol_i || w_out_free;
            end
        end
    end

    assign w_in_xfer = s_valid_i && s_ready_o;
    // sof in ODD drops the held even sample and restarts the pair.
    assign w_as_even = (r_state == EVEN) || s_sof_i;
    assign w_emit    = w_in_xfer && (!w_as_even || s_eol_i);

    always_comb begin
        w_pair = '0;
        if (w_as_even) begin
            w_pair = {1'b1, s_sof_i,
                      (r_have_odd && !s_sof_i) ? r_last_odd : s_data_i,
                      s_data_i};
        end else begin
            w_pair = {s_eol_i, r_sof, s_data_i, r_even};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state    <= EVEN;
            r_rdy      <= 1'b0;
            r_even     <= '0;
            r_last_odd <= '0;
            r_sof      <= 1'b0;
            r_have_odd <= 1'b0;
        end else begin
            r_rdy <= 1'b1;
            if (w_in_xfer) begin
                if (w_as_even) begin
                    r_even <= s_data_i;
                    r_sof  <= s_sof_i;
                    if (s_eol_i) begin
                        r_state    <= EVEN;
                        r_have_odd <= 1'b0;
                        r_last_odd <= '0;
                    end else begin
                        r_state <= ODD;
                        if (s_sof_i) begin
                            r_have_odd <= 1'b0;
                            r_last_odd <= '0;
                        end
                    end
                end else begin
                    r_state <= EVEN;
                    if (s_eol_i) begin
                        r_have_odd <= 1'b0;
                        r_last_odd <= '0;
                    end else begin
                        r_have_odd <= 1'b1;
                        r_last_odd <= s_data_i;
                    end
                end
            end
        end
    end

    dwt_pair_packer_axis_reg #(
        .WIDTH (c_PAIR_W)
    ) u_out_reg (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .s_valid_i (w_emit),
        .s_ready_o (w_out_free),
        .s_data_i  (w_pair),
        .m_valid_o (m_valid_o),
        .m_ready_i (m_ready_i),
        .m_data_o  (w_out_pair)
    );

    assign {m_eol_o, m_sof_o, m_data_o} = w_out_pair;

`ifdef DWT_PACK_ERR_EN
    localparam int                 c_CNT_W   = $clog2(MAXIMUM_SIDE_SIZE) + 1;
    localparam logic [c_CNT_W-1:0] c_MAX_CNT = c_CNT_W'(MAXIMUM_SIDE_SIZE);

    logic [c_CNT_W-1:0] r_count;
    logic               r_err;
    logic [c_CNT_W-1:0] w_count_base;

    assign w_count_base = s_sof_i ? '0 : r_count;

    // Counter saturates at MAXIMUM_SIDE_SIZE+1 so an overlong line stays flagged.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_count <= '0;
            r_err   <= 1'b0;
        end else if (w_in_xfer) begin
            if (s_sof_i && ((r_state == ODD) || (r_count != '0))) begin
                r_err <= 1'b1;
            end
            if (w_count_base >= c_MAX_CNT) begin
                r_err <= 1'b1;
            end
            if (s_eol_i) begin
                r_count <= '0;
            end else if (w_count_base <= c_MAX_CNT) begin
                r_count <= w_count_base + 1'b1;
            end
        end
    end

    assign err_o = r_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dwt_pair_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dwt_pair_packer
// Purpose  : Directed, self-checking bench for dwt_pair_packer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dwt_pair_packer;

    localparam int DW = 16;

    typedef struct {
        logic signed [DW-1:0] odd;
        logic signed [DW-1:0] even;
        logic                 sof;
        logic                 eol;
    } pair_s;

    typedef struct {
        logic signed [DW-1:0] data;
        logic                 sof;
        logic                 eol;
    } beat_s;

    logic                 clk       = 1'b0;
    logic                 rst_i     = 1'b0;
    logic                 s_valid_i = 1'b0;
    logic                 s_sof_i   = 1'b0;
    logic                 s_eol_i   = 1'b0;
    logic signed [DW-1:0] s_data_i  = '0;
    logic                 m_ready_i = 1'b1;
    logic                 s_ready_o;
    logic                 m_valid_o;
    logic                 m_sof_o;
    logic                 m_eol_o;
    logic [2*DW-1:0]      m_data_o;
`ifdef DWT_PACK_ERR_EN
    logic                 err_o;
`endif

    dwt_pair_packer #(.DATA_WIDTH(DW)) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .s_ready_o (s_ready_o),
        .s_valid_i (s_valid_i),
        .s_sof_i   (s_sof_i),
        .s_eol_i   (s_eol_i),
        .s_data_i  (s_data_i),
        .m_ready_i (m_ready_i),
        .m_valid_o (m_valid_o),
        .m_sof_o   (m_sof_o),
        .m_eol_o   (m_eol_o),
        .m_data_o  (m_data_o)
`ifdef DWT_PACK_ERR_EN
        ,
        .err_o     (err_o)
`endif
    );

    always #5 clk = ~clk;

    pair_s exp_q[$];
    pair_s obs[$];
    beat_s beats[$];
    int    n_cmp = 0;
    int    n_fail = 0;
    int    stall_req = 0;
    int    blocked_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Line model: pairs are (x[2k+1], x[2k]); an odd-length line ends with
    // (x[N-2], x[N-1]), or (x[0], x[0]) for a one-sample line.
    logic                 rst_q = 1'b0;
    int                   line_len = 0;
    logic signed [DW-1:0] line_x[$];
    logic                 line_sof[$];
    logic                 prev_stall = 1'b0;
    logic [2*DW+1:0]      prev_out = '0;
    logic                 exp_err = 1'b0;
    pair_s                p;

    always @(posedge clk) rst_q <= rst_i;

    always @(negedge clk) begin
        if (!rst_q) begin
            chk("reset_valid", {63'd0, m_valid_o}, 64'd0);
            chk("reset_out", {30'd0, m_eol_o, m_sof_o, m_data_o}, 64'd0);
        end else begin
            chk("valid_vs_model", {63'd0, m_valid_o}, {63'd0, exp_q.size() != 0});
            if (m_valid_o && exp_q.size() > 0) begin
                p = exp_q[0];
                chk("pair_vs_model", {30'd0, m_eol_o, m_sof_o, m_data_o},
                    {30'd0, p.eol, p.sof, p.odd, p.even});
                if (m_ready_i) begin
                    void'(exp_q.pop_front());
                    p.odd  = m_data_o[2*DW-1:DW];
                    p.even = m_data_o[DW-1:0];
                    p.sof  = m_sof_o;
                    p.eol  = m_eol_o;
                    obs.push_back(p);
                end
            end
            if (prev_stall) begin
                chk("stall_hold", {30'd0, m_eol_o, m_sof_o, m_data_o}, {30'd0, prev_out});
            end
`ifdef DWT_PACK_ERR_EN
            chk("err_vs_model", {63'd0, err_o}, {63'd0, exp_err});
`endif
        end
        prev_stall = rst_i && m_valid_o && !m_ready_i;
        prev_out   = {m_eol_o, m_sof_o, m_data_o};
        if (rst_i && s_valid_i && !s_ready_o) blocked_cnt++;
        if (!rst_i) begin
            exp_q.delete();
            line_x.delete();
            line_sof.delete();
            exp_err = 1'b0;
        end else if (s_valid_i && s_ready_o) begin
            if (s_sof_i) begin
                if (line_x.size() != 0) exp_err = 1'b1;
                if (line_x.size() % 2 == 1) begin
                    // unpaired even sample is discarded; line restarts here
                end
                line_x.delete();
                line_sof.delete();
            end
            line_x.push_back(s_data_i);
            line_sof.push_back(s_sof_i);
            line_len = line_x.size();
            if (line_len % 2 == 0) begin
                p.odd  = line_x[line_len-1];
                p.even = line_x[line_len-2];
                p.sof  = line_sof[line_len-2];
                p.eol  = s_eol_i;
                exp_q.push_back(p);
            end else if (s_eol_i) begin
                p.odd  = (line_len == 1) ? line_x[0] : line_x[line_len-2];
                p.even = line_x[line_len-1];
                p.sof  = line_sof[line_len-1];
                p.eol  = 1'b1;
                exp_q.push_back(p);
            end
            if (s_eol_i) begin
                line_x.delete();
                line_sof.delete();
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (stall_req > 0) begin
                m_ready_i = 1'b0;
                stall_req--;
            end else begin
                m_ready_i = 1'b1;
            end
        end
    end

    task automatic add(input int d, input bit sof, input bit eol);
        beat_s b;
        b.data = DW'(d);
        b.sof  = sof;
        b.eol  = eol;
        beats.push_back(b);
    endtask

    task automatic send_beats();
        beat_s b;
        bit    acc;
        int    guard;
        while (beats.size() > 0) begin
            b         = beats.pop_front();
            s_valid_i = 1'b1;
            s_data_i  = b.data;
            s_sof_i   = b.sof;
            s_eol_i   = b.eol;
            acc       = 1'b0;
            guard     = 0;
            while (!acc) begin
                @(negedge clk);
                acc = s_ready_o;
                @(posedge clk);
                #1;
                guard++;
                if (!acc && guard > 100) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL send_timeout: beat %0d never accepted", b.data);
                    beats.delete();
                    break;
                end
            end
        end
        s_valid_i = 1'b0;
        s_sof_i   = 1'b0;
        s_eol_i   = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && !m_valid_o) done = 1'b1;
        end
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL idle_timeout: pairs pending %0d", exp_q.size());
        end
    endtask

    task automatic check_pair(input string name, input int idx, input int odd, input int even,
                              input bit sof, input bit eol);
        logic [DW-1:0] o;
        logic [DW-1:0] e;
        o = DW'(odd);
        e = DW'(even);
        if (idx < obs.size()) begin
            chk(name, {30'd0, obs[idx].eol, obs[idx].sof, obs[idx].odd, obs[idx].even},
                {30'd0, eol, sof, o, e});
        end else begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: pair %0d missing, got %0d pairs", name, idx, obs.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {63'd0, m_valid_o}, 64'd0);
        chk("rst_data", {32'd0, m_data_o}, 64'd0);
        chk("rst_sof_eol", {62'd0, m_sof_o, m_eol_o}, 64'd0);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rst", {63'd0, s_ready_o}, 64'd1);

        // Even-length line
        obs.delete();
        add(10, 1, 0); add(11, 0, 0); add(12, 0, 0); add(13, 0, 1);
        send_beats();
        wait_idle();
        chk("even_line_count", obs.size(), 2);
        check_pair("even_line_p0", 0, 11, 10, 1, 0);
        check_pair("even_line_p1", 1, 13, 12, 0, 1);

        // Odd-length line mirrors x[N-2]
        obs.delete();
        add(1, 1, 0); add(2, 0, 0); add(3, 0, 0); add(4, 0, 0); add(5, 0, 1);
        send_beats();
        wait_idle();
        chk("odd_line_count", obs.size(), 3);
        check_pair("odd_line_p0", 0, 2, 1, 1, 0);
        check_pair("odd_line_p1", 1, 4, 3, 0, 0);
        check_pair("odd_line_p2", 2, 4, 5, 0, 1);

        // Single-sample line
        obs.delete();
        add(-7, 1, 1);
        send_beats();
        wait_idle();
        chk("single_count", obs.size(), 1);
        check_pair("single_p0", 0, -7, -7, 1, 1);

        // Full-rate input with a 4-cycle output stall after the first pair
        obs.delete();
        blocked_cnt = 0;
        for (int i = 40; i <= 48; i++) add(i, i == 40, i == 48);
        fork
            send_beats();
            begin
                for (int i = 0; i < 50 && obs.size() == 0; i++) @(posedge clk);
                stall_req = 4;
            end
        join
        wait_idle();
        chk("stall_count", obs.size(), 5);
        chk("stall_blocked", {63'd0, blocked_cnt > 0}, 64'd1);
        check_pair("stall_p0", 0, 41, 40, 1, 0);
        check_pair("stall_p2", 2, 45, 44, 0, 0);
        check_pair("stall_p4", 4, 47, 48, 0, 1);

        // sof on the second sample of a pair discards the held even
        obs.delete();
        add(3, 1, 0); add(8, 1, 0); add(9, 0, 1);
        send_beats();
        wait_idle();
        chk("trunc_count", obs.size(), 1);
        check_pair("trunc_p0", 0, 9, 8, 1, 1);
`ifdef DWT_PACK_ERR_EN
        chk("trunc_err", {63'd0, err_o}, 64'd1);
`endif

        // Reset with a held even sample
        obs.delete();
        add(20, 1, 0);
        send_beats();
        rst_i = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_valid", {63'd0, m_valid_o}, 64'd0);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        add(30, 1, 0); add(31, 0, 1);
        send_beats();
        wait_idle();
        chk("midrst_count", obs.size(), 1);
        check_pair("midrst_p0", 0, 31, 30, 1, 1);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
